// File: rtl/logic_pipe.sv
// Pipelined bitwise logic unit (NOR/OR/AND/XOR) with an accumulator feedback path
// and a wrapping count of emitted results.
module logic_pipe #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2,
  parameter int unsigned CntW  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [1:0]       op_i,
  input  logic             acc_en_i,
  input  logic             clr_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             out_valid_o,
  output logic [Width-1:0] y_o,
  output logic [Width-1:0] acc_o,
  output logic [CntW-1:0]  count_o
);

  localparam logic [1:0] OpNor = 2'd0;
  localparam logic [1:0] OpOr  = 2'd1;
  localparam logic [1:0] OpAnd = 2'd2;
  localparam logic [1:0] OpXor = 2'd3;

  logic [Width-1:0] opnd_b;
  logic [Width-1:0] issue_res;

  logic [Depth-1:0] v_q, v_d;
  logic [Width-1:0] d_q [Depth];
  logic [Width-1:0] d_d [Depth];
  logic [Width-1:0] acc_q, acc_d;
  logic [CntW-1:0]  count_q, count_d;

  // Feedback uses the pre-update accumulator, so chained issues need no stall.
  always_comb begin
    opnd_b    = acc_en_i ? acc_q : b_i;
    issue_res = '0;
    unique case (op_i)
      OpNor:   issue_res = ~(a_i | opnd_b);
      OpOr:    issue_res = a_i | opnd_b;
      OpAnd:   issue_res = a_i & opnd_b;
      OpXor:   issue_res = a_i ^ opnd_b;
      default: issue_res = '0;
    endcase
  end

  always_comb begin
    v_d    = '0;
    v_d[0] = in_valid_i;
    d_d[0] = in_valid_i ? issue_res : d_q[0];
    for (int i = 1; i < Depth; i++) begin
      v_d[i] = v_q[i-1];
      d_d[i] = v_q[i-1] ? d_q[i-1] : d_q[i];
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (in_valid_i && acc_en_i) begin
      acc_d = issue_res;
    end
  end

  always_comb begin
    count_d = count_q;
    if (v_q[Depth-1]) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      for (int i = 0; i < Depth; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign out_valid_o = v_q[Depth-1];
  assign y_o         = d_q[Depth-1];
  assign acc_o       = acc_q;
  assign count_o     = count_q;

endmodule

// File: doc/logic_pipe.md
# logic_pipe

Parametrised, pipelined successor to the combinational multibit NOR test unit. It samples two WIDTH-bit operands and a 2-bit opcode (NOR/OR/AND/XOR) on a valid strobe and returns the result DEPTH cycles later, one result per cycle. An accumulator mode feeds the running result back as the second operand. It exists to exercise sequential placement and routing: register chains, feedback loops and a wrapping counter, driven from the switch bank and observed on the light bank.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- DEPTH, 2, pipeline latency in cycles (≥1)
- CNT_W, 8, width of the result counter
- CLK  input  1  clock; all state updates on the rising edge
- RST_N  input  1  asynchronous, active-low reset
- IN_VALID  input  1  issue strobe; operands are sampled when high
- OP  input  2  0 = NOR, 1 = OR, 2 = AND, 3 = XOR
- ACC_EN  input  1  when high, the second operand is ACC instead of B
- CLR  input  1  synchronous accumulator clear
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- OUT_VALID  output  1  result strobe
- Y  output  WIDTH  result; holds the last valid result
- ACC  output  WIDTH  accumulator register
- COUNT  output  CNT_W  number of OUT_VALID pulses, modulo 2^CNT_W

## Operation
- Operand selection: S = ACC_EN ? ACC : B.
- Issue result: R = op(A, S), computed combinationally in the issue cycle.
  - NOR: ~(A|S)
  - OR: A|S
  - AND: A&S
  - XOR: A^S
- All operations are bitwise. There is no carry and no width growth; R is exactly WIDTH bits.
- Pipeline structure: DEPTH stages, each holding a valid bit v[i] and a data word d[i].
  - Stage 0 loads v = IN_VALID. It loads d = R only when IN_VALID is high.
  - Stage i loads v from stage i-1 every cycle. It loads d from stage i-1 only when v[i-1] is high; otherwise d holds.
  - OUT_VALID = v[DEPTH-1] and Y = d[DEPTH-1], so Y holds its value between results.
- Accumulator, evaluated at each rising edge:
  - CLR high: ACC ← 0. CLR has priority.
  - Otherwise, IN_VALID and ACC_EN both high: ACC ← R.
  - Otherwise: ACC holds.
- Accumulator feedback takes effect at issue, not at output. Back-to-back accumulate issues therefore chain with no hazard and no stall.
- CLR in the same cycle as IN_VALID with ACC_EN:
  - The issued result uses the pre-clear ACC.
  - That result enters the pipeline normally.
  - ACC becomes 0.
- COUNT increments by 1 on every edge where OUT_VALID is high. It wraps from 2^CNT_W−1 to 0.
- OP, ACC_EN, A and B are don't-care when IN_VALID is low.
- There is no backpressure. The block always accepts input and always presents output.

## Timing
- Reset (RST_N low, asynchronous): all v[i] = 0, all d[i] = 0, OUT_VALID = 0, Y = 0, ACC = 0, COUNT = 0. These values hold for as long as RST_N is low.
- The first issue is accepted on the first rising edge after RST_N deasserts.
- Latency: IN_VALID sampled at edge k → OUT_VALID high and Y valid during cycle k+DEPTH, i.e. visible after edge k+DEPTH−1.
  - With DEPTH = 1, Y is valid in the cycle after issue.
- Throughput: one result per cycle. Results leave in issue order, and gaps in IN_VALID are preserved at the output.
- ACC updates at the issue edge. The new ACC is usable as an operand in the very next cycle.
- COUNT updates on the edge that ends an OUT_VALID cycle, so it lags OUT_VALID by one cycle.
- Reset mid-flight: all in-flight results are discarded. Nothing emerges after reset releases.

## Test plan
All scenarios use WIDTH = 8, DEPTH = 2, CNT_W = 8.
- Reset: hold RST_N low with random inputs toggling → Y = 0x00, OUT_VALID = 0, ACC = 0x00, COUNT = 0 throughout.
- Single NOR: issue A = 0x0F, B = 0x30, OP = 0 at edge k → OUT_VALID = 1 and Y = 0xC0 for exactly one cycle after edge k+1; afterwards Y holds 0xC0 and COUNT = 1.
- Back-to-back opcodes: A = 0xF0, B = 0xCC, OP = 0, 1, 2, 3 on four consecutive cycles → Y = 0x03, 0xFC, 0xC0, 0x3C on consecutive cycles with OUT_VALID high for 4 cycles; COUNT = 4.
- XOR accumulate: CLR for one cycle, then ACC_EN = 1, OP = 3, A = 0x01, 0x02, 0x04 back-to-back → ACC = 0x01, 0x03, 0x07 after the respective edges; Y = 0x01, 0x03, 0x07 two cycles later.
- CLR collision: with ACC = 0x07, issue CLR = 1, IN_VALID = 1, ACC_EN = 1, OP = 1, A = 0x10 → ACC = 0x00 next cycle; Y = 0x17 at latency 2.
- Reset mid-flight and wrap:
  - Issue one valid, then pull RST_N low before it reaches the output → OUT_VALID never rises and COUNT stays 0.
  - Separately, issue 256 consecutive valids → COUNT returns to 0.
